// File: rtl/pixel_window_feeder.sv
// Streams rows of pixels into an 8-tap sliding window with replicated-edge padding,
// emitting one window per row pixel over a valid/ready handshake.
module pixel_window_feeder #(
  parameter int XW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_pixel,
  input  logic          in_last,
  input  logic [1:0]    in_frac,
  output logic          win_valid,
  input  logic          out_ready,
  output logic [63:0]   win_pixels,
  output logic [XW-1:0] win_x,
  output logic [1:0]    win_frac,
  output logic          win_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [63:0]   sr_r;
  logic [2:0]    cnt_r;
  logic [1:0]    flush_cnt_r;
  logic [XW-1:0] x_r;
  logic [1:0]    frac_r;
  logic          valid_r;
  logic          last_r;

  logic          can_shift_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          consume_s;
  logic          start_s;
  logic          shift_s;
  logic          final_s;
  logic          produce_s;
  logic [7:0]    ins_s;

  assign can_shift_s = !valid_r || out_ready;
  assign in_ready_s  = ((state_r == IDLE) || (state_r == RUN)) && can_shift_s;
  assign accept_s    = in_valid && in_ready_s;
  assign consume_s   = valid_r && out_ready;
  // A window exists once four shifts have followed the broadcast of the row's first pixel.
  assign produce_s   = shift_s && (cnt_r >= 3'd3);

  // Next-state and shift decode.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    shift_s = 1'b0;
    final_s = 1'b0;
    ins_s   = in_pixel;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          start_s = 1'b1;
          state_s = in_last ? FLUSH : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          shift_s = 1'b1;
          state_s = in_last ? FLUSH : RUN;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        ins_s = sr_r[63:56];
        if (can_shift_s) begin
          shift_s = 1'b1;
          if (flush_cnt_r == 2'd3) begin
            final_s = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = FLUSH;
          end
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Window shift register, counters and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      sr_r        <= 64'd0;
      cnt_r       <= 3'd0;
      flush_cnt_r <= 2'd0;
      x_r         <= '0;
      frac_r      <= 2'd0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        sr_r        <= {8{in_pixel}};
        cnt_r       <= 3'd0;
        flush_cnt_r <= 2'd0;
        frac_r      <= in_frac;
      end else if (shift_s) begin
        sr_r  <= {ins_s, sr_r[63:8]};
        cnt_r <= (cnt_r == 3'd4) ? 3'd4 : cnt_r + 3'd1;
        if (state_r == FLUSH) begin
          flush_cnt_r <= flush_cnt_r + 2'd1;
        end
      end
      // Row start wins over a same-cycle consume of the previous row's last window.
      if (start_s) begin
        x_r <= '0;
      end else if (consume_s) begin
        x_r <= x_r + {{(XW-1){1'b0}}, 1'b1};
      end
      if (produce_s) begin
        valid_r <= 1'b1;
        last_r  <= final_s;
      end else if (consume_s) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign win_valid  = valid_r;
  assign win_pixels = sr_r;
  assign win_x      = x_r;
  assign win_frac   = frac_r;
  assign win_last   = last_r;

endmodule

// File: tb/tb_pixel_window_feeder.sv
// Directed bench for pixel_window_feeder: padding, stalls, row boundaries and reset.
module tb_pixel_window_feeder;

  typedef logic [7:0] row_t [0:15];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = 8'd0;
  logic        in_last = 1'b0;
  logic [1:0]  in_frac = 2'd0;
  logic        win_valid;
  logic        out_ready = 1'b1;
  logic [63:0] win_pixels;
  logic [7:0]  win_x;
  logic [1:0]  win_frac;
  logic        win_last;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] q_pix[$];
  int          q_x[$];
  logic [1:0]  q_frac[$];
  logic        q_last[$];

  pixel_window_feeder #(.XW(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_last(in_last), .in_frac(in_frac),
    .win_valid(win_valid), .out_ready(out_ready), .win_pixels(win_pixels),
    .win_x(win_x), .win_frac(win_frac), .win_last(win_last)
  );

  always #5 clock = ~clock;

  // Record every window that the next rising edge will consume.
  always @(negedge clock) begin
    if (!reset && win_valid && out_ready) begin
      q_pix.push_back(win_pixels);
      q_x.push_back(int'(win_x));
      q_frac.push_back(win_frac);
      q_last.push_back(win_last);
    end
  end

  function automatic logic [63:0] exp_win(input row_t r, input int n, input int x);
    logic [63:0] w;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = x - 3 + k;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      w[k*8 +: 8] = r[idx];
    end
    return w;
  endfunction

  task automatic clear_q();
    q_pix.delete(); q_x.delete(); q_frac.delete(); q_last.delete();
  endtask

  task automatic send_row(input row_t r, input int n, input logic [1:0] f);
    logic acc;
    int cyc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pixel = r[i];
      in_last  = (i == n - 1);
      in_frac  = f;
      cyc = 0;
      do begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock);
        #1;
        cyc++;
      end while (!acc && cyc < 64);
      compared++;
      if (!acc) begin
        mismatched++;
        $display("FAIL accept_timeout pixel %0d: in_ready stayed %b, required 1", i, acc);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    compared += 6;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (win_valid !== 1'b0) begin mismatched++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
    if (win_x !== 8'd0) begin mismatched++; $display("FAIL reset_win_x got %0d want 0", win_x); end
    if (win_frac !== 2'd0) begin mismatched++; $display("FAIL reset_win_frac got %0d want 0", win_frac); end
    if (win_last !== 1'b0) begin mismatched++; $display("FAIL reset_win_last got %b want 0", win_last); end
    if (win_pixels !== 64'd0) begin mismatched++; $display("FAIL reset_win_pixels got %h want 0", win_pixels); end
  endtask

  task automatic test_row6();
    row_t r = '{default: 8'd0};
    r[0] = 8'd10; r[1] = 8'd20; r[2] = 8'd30; r[3] = 8'd40; r[4] = 8'd50; r[5] = 8'd60;
    clear_q();
    out_ready = 1'b1;
    send_row(r, 6, 2'd2);
    repeat (12) @(posedge clock);
    #1;
    compared++;
    if (q_pix.size() !== 6) begin mismatched++; $display("FAIL row6_count got %0d want 6", q_pix.size()); end
    if (q_pix.size() >= 6) begin
      compared += 3;
      if (q_pix[0] !== 64'h3228_1E14_0A0A_0A0A) begin mismatched++; $display("FAIL row6_x0 got %h want 32281e140a0a0a0a", q_pix[0]); end
      if (q_pix[5] !== 64'h3C3C_3C3C_3C32_281E) begin mismatched++; $display("FAIL row6_x5 got %h want 3c3c3c3c3c32281e", q_pix[5]); end
      if (q_last[5] !== 1'b1) begin mismatched++; $display("FAIL row6_last got %b want 1", q_last[5]); end
    end
    for (int i = 0; i < q_pix.size() && i < 6; i++) begin
      compared++;
      if (q_pix[i] !== exp_win(r, 6, i) || q_x[i] != i || q_frac[i] !== 2'd2 || q_last[i] !== (i == 5)) begin
        mismatched++;
        $display("FAIL row6_win%0d got x=%0d frac=%0d last=%b pix=%h want x=%0d frac=2 last=%b pix=%h",
                 i, q_x[i], q_frac[i], q_last[i], q_pix[i], i, (i == 5), exp_win(r, 6, i));
      end
    end
  endtask

  task automatic test_single();
    row_t r = '{default: 8'd0};
    r[0] = 8'd77;
    clear_q();
    send_row(r, 1, 2'd0);
    repeat (10) @(posedge clock);
    #1;
    compared++;
    if (q_pix.size() !== 1) begin mismatched++; $display("FAIL single_count got %0d want 1", q_pix.size()); end
    if (q_pix.size() >= 1) begin
      compared += 3;
      if (q_pix[0] !== 64'h4D4D_4D4D_4D4D_4D4D) begin mismatched++; $display("FAIL single_pix got %h want 4d4d4d4d4d4d4d4d", q_pix[0]); end
      if (q_x[0] != 0) begin mismatched++; $display("FAIL single_x got %0d want 0", q_x[0]); end
      if (q_last[0] !== 1'b1) begin mismatched++; $display("FAIL single_last got %b want 1", q_last[0]); end
    end
  endtask

  task automatic test_stall();
    row_t r = '{default: 8'd0};
    logic found;
    logic [63:0] held;
    for (int i = 0; i < 8; i++) r[i] = 8'h11 * (i + 1);
    clear_q();
    found = 1'b0;
    fork
      send_row(r, 8, 2'd1);
      begin
        for (int c = 0; c < 60 && !found; c++) begin
          @(posedge clock);
          #1;
          if (win_valid && win_x == 8'd2) found = 1'b1;
        end
        if (found) begin
          out_ready = 1'b0;
          held = win_pixels;
          for (int s = 0; s < 3; s++) begin
            @(posedge clock);
            #1;
            compared++;
            if (win_valid !== 1'b1 || win_x !== 8'd2 || win_pixels !== held || in_ready !== 1'b0) begin
              mismatched++;
              $display("FAIL stall_hold cycle %0d got valid=%b x=%0d pix=%h in_ready=%b want 1/2/%h/0",
                       s, win_valid, win_x, win_pixels, in_ready, held);
            end
          end
          out_ready = 1'b1;
        end
      end
    join
    compared++;
    if (!found) begin mismatched++; $display("FAIL stall_find got none want window x=2"); end
    repeat (16) @(posedge clock);
    #1;
    compared++;
    if (q_pix.size() !== 8) begin mismatched++; $display("FAIL stall_count got %0d want 8", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 8; i++) begin
      compared++;
      if (q_pix[i] !== exp_win(r, 8, i) || q_x[i] != i || q_last[i] !== (i == 7)) begin
        mismatched++;
        $display("FAIL stall_win%0d got x=%0d last=%b pix=%h want x=%0d pix=%h",
                 i, q_x[i], q_last[i], q_pix[i], i, exp_win(r, 8, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t a = '{default: 8'd0};
    row_t b = '{default: 8'd0};
    a[0] = 8'hA1; a[1] = 8'hA2; a[2] = 8'hA3;
    b[0] = 8'hB1; b[1] = 8'hB2; b[2] = 8'hB3; b[3] = 8'hB4;
    clear_q();
    send_row(a, 3, 2'd1);
    send_row(b, 4, 2'd3);
    repeat (14) @(posedge clock);
    #1;
    compared++;
    if (q_pix.size() !== 7) begin mismatched++; $display("FAIL b2b_count got %0d want 7", q_pix.size()); end
    if (q_pix.size() >= 4) begin
      compared++;
      if (q_pix[3] !== 64'hB4B4_B3B2_B1B1_B1B1) begin mismatched++; $display("FAIL b2b_first_b got %h want b4b4b3b2b1b1b1b1", q_pix[3]); end
    end
    for (int i = 0; i < q_pix.size() && i < 7; i++) begin
      compared++;
      if (i < 3) begin
        if (q_pix[i] !== exp_win(a, 3, i) || q_x[i] != i || q_frac[i] !== 2'd1 || q_last[i] !== (i == 2)) begin
          mismatched++;
          $display("FAIL b2b_a%0d got x=%0d frac=%0d pix=%h want x=%0d frac=1 pix=%h", i, q_x[i], q_frac[i], q_pix[i], i, exp_win(a, 3, i));
        end
      end else begin
        if (q_pix[i] !== exp_win(b, 4, i - 3) || q_x[i] != i - 3 || q_frac[i] !== 2'd3 || q_last[i] !== (i == 6)) begin
          mismatched++;
          $display("FAIL b2b_b%0d got x=%0d frac=%0d pix=%h want x=%0d frac=3 pix=%h", i - 3, q_x[i], q_frac[i], q_pix[i], i - 3, exp_win(b, 4, i - 3));
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    row_t r = '{default: 8'd0};
    row_t s = '{default: 8'd0};
    for (int i = 0; i < 5; i++) r[i] = 8'h51 + i[7:0];
    s[0] = 8'h05; s[1] = 8'h06;
    clear_q();
    send_row(r, 5, 2'd2);
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    compared += 2;
    if (win_valid !== 1'b0) begin mismatched++; $display("FAIL rstflush_valid got %b want 0", win_valid); end
    if (win_x !== 8'd0) begin mismatched++; $display("FAIL rstflush_x got %0d want 0", win_x); end
    repeat (10) @(posedge clock);
    #1;
    compared++;
    if (q_pix.size() !== 0) begin mismatched++; $display("FAIL rstflush_leak got %0d windows want 0", q_pix.size()); end
    send_row(s, 2, 2'd1);
    repeat (10) @(posedge clock);
    #1;
    compared++;
    if (q_pix.size() !== 2) begin mismatched++; $display("FAIL after_rst_count got %0d want 2", q_pix.size()); end
    if (q_pix.size() >= 2) begin
      compared += 4;
      if (q_pix[0] !== 64'h0606_0606_0505_0505 || q_x[0] != 0) begin mismatched++; $display("FAIL after_rst_x0 got x=%0d pix=%h want x=0 pix=0606060605050505", q_x[0], q_pix[0]); end
      if (q_pix[1] !== 64'h0606_0606_0605_0505 || q_x[1] != 1) begin mismatched++; $display("FAIL after_rst_x1 got x=%0d pix=%h want x=1 pix=0606060606050505", q_x[1], q_pix[1]); end
      if (q_last[1] !== 1'b1 || q_last[0] !== 1'b0) begin mismatched++; $display("FAIL after_rst_last got %b%b want 01", q_last[0], q_last[1]); end
      if (q_frac[0] !== 2'd1) begin mismatched++; $display("FAIL after_rst_frac got %0d want 1", q_frac[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_row6();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
